mpadd_seq_ctrl: RTL and testbench
=================================

Name: mpadd_seq_ctrl

Overview:
- Sequencer for multi-precision addition on the 16-bit add-with-carry datapath.
- Accepts a command giving the word count and initial carry-in, then streams operand word pairs least-significant word first.
- Drives the adder once per word, chaining carry-out into the next word's carry-in.
- Emits registered result words plus the final carry and whole-result zero flag; sits between the issue logic and the arithmetic unit, with the adder time-shared across words.

Parameters:
- MAX_WORDS, 8, maximum words per operation.
- CNT_W, 4, word-counter width; must satisfy CNT_W >= clog2(MAX_WORDS+1).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_valid  in  1  command valid.
- start_ready  out  1  high only in IDLE.
- start_nwords  in  CNT_W  words in operation; 0 treated as 1; values >MAX_WORDS clamped to MAX_WORDS.
- start_cin  in  1  carry-in for word 0.
- op_valid  in  1  operand pair valid.
- op_ready  out  1  operand pair accepted when op_valid and op_ready are both high.
- op_a  in  16  operand A word.
- op_b  in  16  operand B word.
- res_valid  out  1  result word valid.
- res_ready  in  1  consumer accepts result.
- res_d  out  16  result word.
- res_last  out  1  marks final word of the operation.
- res_carry  out  1  final carry-out; meaningful only when res_last=1, else 0.
- res_zero  out  1  high iff every result word of the operation is 0x0000; meaningful only when res_last=1, else 0.
- busy  out  1  high in RUN or DRAIN.

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE.
  - All outputs 0 except start_ready=1.
  - carry, zero accumulator and counter cleared.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start_ready=1.
  - On a start handshake: latch the effective count into remaining, carry<=start_cin, zacc<=1; go to RUN.
  - Operands presented in IDLE are not accepted (op_ready=0).
- RUN:
  - op_ready = (!res_valid || res_ready).
  - On an operand handshake:
    - {cout,sum} = op_a + op_b + carry (17-bit).
    - Register res_d<=sum and res_valid<=1; carry<=cout; zacc<=zacc & (sum==0); remaining decrements.
    - If this was the final word: res_last<=1, res_carry<=cout, res_zero<=zacc & (sum==0); go to DRAIN.
- DRAIN:
  - op_ready=0.
  - Result held until res_ready; on the handshake: res_valid<=0, res_last/res_carry/res_zero<=0; go to IDLE.
  - start_ready rises the cycle after the last result handshake.
- Latency and throughput:
  - Latency is 1 cycle from operand handshake to res_valid.
  - With res_ready held high, one word is accepted per cycle, and back-to-back commands are separated by exactly one IDLE cycle.
- Backpressure: a result not yet accepted holds res_d, res_last and flags stable; no operand is accepted until the output register frees. Simultaneous result accept and new operand accept in the same cycle is legal (pass-through of the register).
- Carry behaviour: carry-out of word k is the carry-in of word k+1. Carry wraps only within the 17-bit add, and the final carry is reported, never dropped.
- Ignored inputs: start_valid while busy is ignored with no effect; op_valid outside RUN is ignored.
- Reset mid-operation aborts immediately: in-flight result discarded, carry cleared, next command starts clean.
- No X propagation: res_d holds its last value when res_valid=0; the bench must only compare while res_valid=1.

Decomposition:
- Shared package mpadd_pkg holds:
  - state enum {IDLE, RUN, DRAIN}.
  - DATA_W=16 constant.
  - Clamp helper for the word count.
- One sub-module, add16_cin: combinational 16-bit adder with carry-in, producing sum and carry-out, instantiated once and shared across all words.

Test Plan:
- Single word, nwords=1, cin=0, A=0x1234, B=0x0001 -> res_d=0x1235, res_last=1, res_carry=0, res_zero=0, latency 1 cycle.
- Carry chain, nwords=2, cin=0:
  - (0xFFFF,0x0001) -> 0x0000.
  - (0x0000,0x0000) -> 0x0001, last=1, carry=0, zero=0.
- Zero and carry out, nwords=3, cin=0:
  - (0x8000,0x8000) -> 0x0000.
  - (0xFFFF,0x0000) -> 0x0000.
  - (0xFFFF,0x0000) -> 0x0000, last=1, carry=1, zero=1.
- Carry-in, nwords=2, cin=1, both words (0xFFFF,0xFFFF) -> 0xFFFF, 0xFFFF, final carry=1, zero=0.
- Backpressure: nwords=3, res_ready low 3 cycles after word 0 -> op_ready=0, res_d stable for those 3 cycles; results in order, no loss or duplication.
- Reset and edge cases:
  - rst_n pulsed low after word 1 of 4 -> outputs reset, start_ready=1; next command with cin=0 adding (0x0001,0x0001) gives 0x0002.
  - start_nwords=0 -> exactly one word processed.
  - start_valid during RUN -> ignored.

Source files
------------

// File: rtl/mpadd_pkg.sv
// Shared types, widths and the word-count clamp used by the multi-precision
// add sequencer and its adder.
package mpadd_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // A request for zero words still performs one word; oversize requests saturate.
  function automatic int unsigned clamp_words(input int unsigned n,
                                              input int unsigned max_words);
    if (n == 0) return 1;
    if (n > max_words) return max_words;
    return n;
  endfunction

endpackage

// File: rtl/add16_cin.sv
// Combinational 16-bit add-with-carry slice, time-shared by the sequencer
// across all words of an operation.
module add16_cin
  import mpadd_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] sum,
  output logic              cout
);

  logic [DATA_W:0] total;

  assign total       = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
  assign {cout, sum} = total;

endmodule

// File: rtl/mpadd_seq_ctrl.sv
// Multi-precision add sequencer: takes a word-count command, streams operand
// pairs LSW first through one shared adder and emits registered result words.
module mpadd_seq_ctrl
  import mpadd_pkg::*;
#(
  parameter int MAX_WORDS = 8,
  parameter int CNT_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [CNT_W-1:0]  start_nwords,
  input  logic              start_cin,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_d,
  output logic              res_last,
  output logic              res_carry,
  output logic              res_zero,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic              carry_q, carry_d;
  logic              zacc_q, zacc_d;
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_d_q, res_d_d;
  logic              res_last_q, res_last_d;
  logic              res_carry_q, res_carry_d;
  logic              res_zero_q, res_zero_d;

  logic [DATA_W-1:0] sum;
  logic              cout;
  logic              op_hs;
  logic              res_hs;
  logic              sum_zero;
  logic              final_word;

  add16_cin u_add (
    .a    (op_a),
    .b    (op_b),
    .cin  (carry_q),
    .sum  (sum),
    .cout (cout)
  );

  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  // The output register frees when it is empty or being drained this cycle.
  assign op_ready    = (state_q == RUN) && (!res_valid_q || res_ready);

  assign op_hs      = op_valid && op_ready;
  assign res_hs     = res_valid_q && res_ready;
  assign sum_zero   = (sum == '0);
  assign final_word = (remaining_q == CNT_W'(1));

  assign res_valid = res_valid_q;
  assign res_d     = res_d_q;
  assign res_last  = res_last_q;
  assign res_carry = res_carry_q;
  assign res_zero  = res_zero_q;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    carry_d     = carry_q;
    zacc_d      = zacc_q;
    res_valid_d = res_valid_q;
    res_d_d     = res_d_q;
    res_last_d  = res_last_q;
    res_carry_d = res_carry_q;
    res_zero_d  = res_zero_q;

    case (state_q)
      IDLE: begin
        if (start_valid) begin
          remaining_d = CNT_W'(clamp_words(32'(start_nwords), 32'(MAX_WORDS)));
          carry_d     = start_cin;
          zacc_d      = 1'b1;
          state_d     = RUN;
        end
      end

      RUN: begin
        if (res_hs) begin
          res_valid_d = 1'b0;
        end
        if (op_hs) begin
          res_d_d     = sum;
          res_valid_d = 1'b1;
          carry_d     = cout;
          zacc_d      = zacc_q & sum_zero;
          remaining_d = remaining_q - CNT_W'(1);
          if (final_word) begin
            res_last_d  = 1'b1;
            res_carry_d = cout;
            res_zero_d  = zacc_q & sum_zero;
            state_d     = DRAIN;
          end
        end
      end

      DRAIN: begin
        if (res_hs) begin
          res_valid_d = 1'b0;
          res_last_d  = 1'b0;
          res_carry_d = 1'b0;
          res_zero_d  = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      carry_q     <= 1'b0;
      zacc_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_d_q     <= '0;
      res_last_q  <= 1'b0;
      res_carry_q <= 1'b0;
      res_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      carry_q     <= carry_d;
      zacc_q      <= zacc_d;
      res_valid_q <= res_valid_d;
      res_d_q     <= res_d_d;
      res_last_q  <= res_last_d;
      res_carry_q <= res_carry_d;
      res_zero_q  <= res_zero_d;
    end
  end

endmodule

// File: tb/tb_mpadd_seq_ctrl.sv
// Self-checking bench for mpadd_seq_ctrl: each command is modelled as one wide
// integer addition and the streamed result words are compared against it.
module tb_mpadd_seq_ctrl;

  localparam int MAXW = 8;
  localparam int CW   = 4;
  localparam int BIGW = MAXW * 16 + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_valid;
  logic          start_ready;
  logic [CW-1:0] start_nwords;
  logic          start_cin;
  logic          op_valid;
  logic          op_ready;
  logic [15:0]   op_a;
  logic [15:0]   op_b;
  logic          res_valid;
  logic          res_ready;
  logic [15:0]   res_d;
  logic          res_last;
  logic          res_carry;
  logic          res_zero;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] va [MAXW];
  logic [15:0] vb [MAXW];

  mpadd_seq_ctrl #(.MAX_WORDS(MAXW), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .start_nwords (start_nwords),
    .start_cin    (start_cin),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_a         (op_a),
    .op_b         (op_b),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_d        (res_d),
    .res_last     (res_last),
    .res_carry    (res_carry),
    .res_zero     (res_zero),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // mode 0: always ready/valid; mode 1: random valid/ready plus stray starts;
  // mode 2: result consumer stalls 3 cycles after word 0.
  // abort_after >= 0 pulses reset once that many words have been accepted.
  task automatic run_cmd(input int n_raw, input bit cin, input int mode, input int abort_after);
    int            eff;
    logic [BIGW-1:0] ba, bb, tot, cw;
    logic [15:0]   expw [MAXW];
    bit            exp_c, exp_z, exp_valid, chk_stable, op_hs, res_hs, lastw;
    logic [15:0]   prev_d;
    logic          prev_last;
    int            tx, rx, cyc, hold;

    eff = (n_raw == 0) ? 1 : ((n_raw > MAXW) ? MAXW : n_raw);
    ba = '0;
    bb = '0;
    for (int i = 0; i < eff; i++) begin
      ba[16*i +: 16] = va[i];
      bb[16*i +: 16] = vb[i];
    end
    cw  = '0;
    cw[0] = cin;
    tot = ba + bb + cw;
    exp_z = 1'b1;
    for (int i = 0; i < eff; i++) begin
      expw[i] = tot[16*i +: 16];
      if (expw[i] != 16'h0) exp_z = 1'b0;
    end
    exp_c = tot[16*eff];

    @(negedge clk);
    start_valid  = 1'b1;
    start_nwords = CW'(n_raw);
    start_cin    = cin;
    op_valid     = 1'b0;
    res_ready    = 1'b1;
    #1;
    cyc = 0;
    while (!start_ready && cyc < 20) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check("start_ready_idle", start_ready, 1);
    @(posedge clk);

    tx = 0; rx = 0; cyc = 0; hold = 0;
    exp_valid = 1'b0; chk_stable = 1'b0; prev_d = '0; prev_last = 1'b0;
    while (rx < eff && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (abort_after >= 0 && tx == abort_after) break;
      start_valid  = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      start_nwords = CW'($urandom);
      start_cin    = 1'($urandom);
      op_valid     = (tx < eff) && (mode != 1 || $urandom_range(0, 2) != 0);
      if (op_valid) begin
        op_a = va[tx];
        op_b = vb[tx];
      end else begin
        op_a = 16'($urandom);
        op_b = 16'($urandom);
      end
      res_ready = (mode == 1) ? ($urandom_range(0, 3) != 0) : (hold == 0);
      if (hold > 0) hold--;
      #1;
      check("busy_run", busy, 1);
      check("start_ready_busy", start_ready, 0);
      check("op_ready", op_ready, (tx < eff) ? (!res_valid || res_ready) : 1'b0);
      if (exp_valid) check("latency", res_valid, 1);
      if (chk_stable) begin
        check("hold_res_d", res_d, prev_d);
        check("hold_res_last", res_last, prev_last);
      end
      op_hs  = op_valid && op_ready;
      res_hs = res_valid && res_ready;
      if (res_hs) begin
        lastw = (rx == eff - 1);
        check($sformatf("res_d[%0d]", rx), res_d, expw[rx]);
        check("res_last", res_last, lastw);
        check("res_carry", res_carry, lastw ? exp_c : 1'b0);
        check("res_zero", res_zero, lastw ? exp_z : 1'b0);
        rx++;
      end
      chk_stable = res_valid && !res_ready;
      prev_d     = res_d;
      prev_last  = res_last;
      exp_valid  = op_hs;
      if (op_hs) begin
        if (mode == 2 && tx == 0) hold = 3;
        tx++;
      end
    end

    if (abort_after >= 0 && tx == abort_after) begin
      rst_n       = 1'b0;
      start_valid = 1'b0;
      op_valid    = 1'b0;
      #1;
      check("rst_res_valid", res_valid, 0);
      check("rst_start_ready", start_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_res_last", res_last, 0);
      check("rst_res_carry", res_carry, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_release_ready", start_ready, 1);
      $display("[TB] cmd n=%0d cin=%0d aborted by reset after %0d words", n_raw, cin, tx);
      return;
    end

    check("words_returned", rx, eff);
    @(negedge clk);
    start_valid = 1'b0;
    op_valid    = 1'b0;
    res_ready   = 1'b1;
    #1;
    check("start_ready_after", start_ready, 1);
    check("busy_after", busy, 0);
    $display("[TB] cmd n=%0d eff=%0d cin=%0d mode=%0d carry=%0d zero=%0d w0=%04h",
             n_raw, eff, cin, mode, exp_c, exp_z, expw[0]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    start_valid  = 1'b0;
    start_nwords = '0;
    start_cin    = 1'b0;
    op_valid     = 1'b0;
    op_a         = '0;
    op_b         = '0;
    res_ready    = 1'b0;
    rst_n        = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_start_ready", start_ready, 1);
    check("reset_op_ready", op_ready, 0);
    check("reset_res_valid", res_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_res_d", res_d, 0);
    check("reset_flags", {res_last, res_carry, res_zero}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    va[0] = 16'h1234; vb[0] = 16'h0001;
    run_cmd(1, 1'b0, 0, -1);

    va[0] = 16'hFFFF; vb[0] = 16'h0001;
    va[1] = 16'h0000; vb[1] = 16'h0000;
    run_cmd(2, 1'b0, 0, -1);

    va[0] = 16'h8000; vb[0] = 16'h8000;
    va[1] = 16'hFFFF; vb[1] = 16'h0000;
    va[2] = 16'hFFFF; vb[2] = 16'h0000;
    run_cmd(3, 1'b0, 0, -1);

    va[0] = 16'hFFFF; vb[0] = 16'hFFFF;
    va[1] = 16'hFFFF; vb[1] = 16'hFFFF;
    run_cmd(2, 1'b1, 0, -1);

    for (int i = 0; i < MAXW; i++) begin
      va[i] = 16'($urandom);
      vb[i] = 16'($urandom);
    end
    run_cmd(3, 1'b0, 2, -1);

    run_cmd(4, 1'b1, 0, 2);
    va[0] = 16'h0001; vb[0] = 16'h0001;
    run_cmd(1, 1'b0, 0, -1);

    va[0] = 16'h0005; vb[0] = 16'h0007;
    va[1] = 16'h1111; vb[1] = 16'h2222;
    run_cmd(0, 1'b0, 0, -1);

    for (int i = 0; i < MAXW; i++) begin
      va[i] = 16'hFFFF;
      vb[i] = (i == 0) ? 16'h0001 : 16'h0000;
    end
    run_cmd(15, 1'b0, 0, -1);

    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < MAXW; i++) begin
        case ($urandom_range(0, 3))
          0:       begin va[i] = 16'hFFFF; vb[i] = 16'($urandom_range(0, 1)); end
          1:       begin va[i] = 16'h0000; vb[i] = 16'h0000; end
          default: begin va[i] = 16'($urandom); vb[i] = 16'($urandom); end
        endcase
      end
      run_cmd($urandom_range(0, 15), 1'($urandom), $urandom_range(0, 2), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
